// File: rtl/multi_edge_counter_pkg.sv
// Shared constants for the multi_edge_counter input event counter.
// Optional debounce logic elsewhere is enabled by defining DEBOUNCE_EN.
package multi_edge_pkg;

    localparam int NCH    = 3;
    localparam int STAB_W = 4;

    localparam int DEF_M = 16;
    localparam int DEF_D = 3;
    localparam int DEF_R = 7;

    typedef enum logic [1:0] {
        SEL_CH0 = 2'd0,
        SEL_CH1 = 2'd1,
        SEL_CH2 = 2'd2,
        SEL_OFF = 2'd3
    } led_sel_e;

endpackage

// File: rtl/multi_edge_counter_edge_channel.sv
// One input channel: 2-flop synchronizer, optional tick-driven debouncer
// (DEBOUNCE_EN), rising-edge detector and wrap-around event counter.
module edge_channel
    import multi_edge_pkg::*;
#(
    parameter int D = DEF_D,
    parameter int R = DEF_R
) (
    input  logic       clk,
    input  logic       notrst,
`ifdef DEBOUNCE_EN
    input  logic       tick,
`endif
    input  logic       clr,
    input  logic       pin,
    output logic       edge_pulse,
    output logic [R:0] count
);

    logic sync_p0;
    logic sync_p1;
    logic level;
    logic level_q;

    // Stage 0/1: metastability chain for the raw pin
    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
        end else begin
            sync_p0 <= pin;
            sync_p1 <= sync_p0;
        end
    end

`ifdef DEBOUNCE_EN
    logic [STAB_W-1:0] stab;

    // Debounce: a new level needs D consecutive differing tick samples
    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            level <= 1'b0;
            stab  <= '0;
        end else if (tick) begin
            if (sync_p1 == level) begin
                stab <= '0;
            end else if (stab == STAB_W'(D - 1)) begin
                level <= sync_p1;
                stab  <= '0;
            end else begin
                stab <= stab + STAB_W'(1);
            end
        end
    end
`else
    localparam int unused_d = D;

    assign level = sync_p1;
`endif

    // Edge detect and count; clr wins over a coincident increment
    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            level_q    <= 1'b0;
            edge_pulse <= 1'b0;
            count      <= '0;
        end else begin
            level_q    <= level;
            edge_pulse <= level & ~level_q;
            if (clr) begin
                count <= '0;
            end else if (edge_pulse) begin
                count <= count + {{R{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/multi_edge_counter.sv
// Three-channel input event counter with shared prescaler and LED mux.
// Define DEBOUNCE_EN to include the prescaler and per-channel debouncers.
module multi_edge_counter
    import multi_edge_pkg::*;
#(
    parameter int M = DEF_M,
    parameter int D = DEF_D,
    parameter int R = DEF_R
) (
    input  logic           clk,
    input  logic           notrst,
    input  logic [NCH-1:0] ioin,
    input  logic           clr,
    input  logic [1:0]     sel,
    output logic [R:0]     count0,
    output logic [R:0]     count1,
    output logic [R:0]     count2,
    output logic [R:0]     led,
    output logic [NCH-1:0] edge_pulse
);

    logic [R:0] cnt [NCH];

`ifdef DEBOUNCE_EN
    logic [M:0] presc;
    logic       tick;

    always_ff @(posedge clk or negedge notrst) begin
        if (!notrst) begin
            presc <= '0;
        end else begin
            presc <= presc + {{M{1'b0}}, 1'b1};
        end
    end

    assign tick = &presc;
`else
    localparam int unused_cfg = M + D;
`endif

    for (genvar g = 0; g < NCH; g++) begin : g_ch
        edge_channel #(
            .D (D),
            .R (R)
        ) u_ch (
            .clk        (clk),
            .notrst     (notrst),
`ifdef DEBOUNCE_EN
            .tick       (tick),
`endif
            .clr        (clr),
            .pin        (ioin[g]),
            .edge_pulse (edge_pulse[g]),
            .count      (cnt[g])
        );
    end

    assign count0 = cnt[0];
    assign count1 = cnt[1];
    assign count2 = cnt[2];

    always_comb begin
        led = '0;
        case (led_sel_e'(sel))
            SEL_CH0: led = cnt[0];
            SEL_CH1: led = cnt[1];
            SEL_CH2: led = cnt[2];
            default: led = '0;
        endcase
    end

endmodule

// File: tb/tb_multi_edge_counter.sv
// Directed bench for multi_edge_counter; adapts to DEBOUNCE_EN defined or not.
module tb_multi_edge_counter;

`ifdef DEBOUNCE_EN
    localparam bit DEB = 1'b1;
`else
    localparam bit DEB = 1'b0;
`endif
    localparam int LONG  = DEB ? 100 : 4;
    localparam int SHORT = DEB ? 20 : 2;
    localparam int G     = DEB ? 0 : 1;

    logic       clk = 1'b0;
    logic       notrst;
    logic [2:0] ioin;
    logic       clr;
    logic [1:0] sel;
    logic [7:0] count0, count1, count2, led;
    logic [2:0] edge_pulse;

    int n_cmp  = 0;
    int n_fail = 0;
    int epc [3];
    int exp_edges [3];

    multi_edge_counter #(.M(3), .D(3), .R(7)) dut (
        .clk        (clk),
        .notrst     (notrst),
        .ioin       (ioin),
        .clr        (clr),
        .sel        (sel),
        .count0     (count0),
        .count1     (count1),
        .count2     (count2),
        .led        (led),
        .edge_pulse (edge_pulse)
    );

    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 3; i++) epc[i] = 0;
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) if (edge_pulse[i]) epc[i] = epc[i] + 1;
    end

    typedef struct {
        logic [2:0] mask;
        bit         shrt;
        int         e0;
        int         e1;
        int         e2;
    } vec_t;

    typedef struct {
        logic [1:0] s;
        int         e;
    } led_vec_t;

    vec_t     tbl [6];
    led_vec_t ltbl [4];

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [2:0] mask, input int hi, input int lo);
        ioin = ioin | mask;
        step(hi);
        ioin = ioin & ~mask;
        step(lo);
        for (int i = 0; i < 3; i++)
            if (mask[i] && (hi >= LONG || !DEB)) exp_edges[i]++;
    endtask

    task automatic do_clr();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic check_counts(input string tag, input int e0, input int e1, input int e2);
        check({tag, "_c0"}, int'(count0), e0);
        check({tag, "_c1"}, int'(count1), e1);
        check({tag, "_c2"}, int'(count2), e2);
    endtask

    initial begin
        tbl[0] = '{3'b001, 1'b0, 1, 0,     0};
        tbl[1] = '{3'b010, 1'b1, 1, G,     0};
        tbl[2] = '{3'b100, 1'b0, 1, G,     1};
        tbl[3] = '{3'b111, 1'b0, 2, G + 1, 2};
        tbl[4] = '{3'b011, 1'b0, 3, G + 2, 2};
        tbl[5] = '{3'b110, 1'b0, 3, G + 3, 3};
        ltbl[0] = '{2'd0, 5};
        ltbl[1] = '{2'd1, 6};
        ltbl[2] = '{2'd2, 7};
        ltbl[3] = '{2'd3, 0};
        for (int i = 0; i < 3; i++) exp_edges[i] = 0;

        // Reset with random pins
        notrst = 1'b0;
        clr    = 1'b0;
        sel    = 2'd0;
        ioin   = 3'($urandom);
        repeat (5) begin
            @(posedge clk);
            #1 ioin = 3'($urandom);
        end
        check_counts("rst", 0, 0, 0);
        check("rst_led", int'(led), 0);
        check("rst_ep", int'(edge_pulse), 0);

        ioin = 3'b000;
        @(negedge clk);
        notrst = 1'b1;
        step(200);
        check_counts("idle", 0, 0, 0);
        check("idle_led", int'(led), 0);
        check("idle_epc", epc[0] + epc[1] + epc[2], 0);

        if (!DEB) begin
            // 2-cycle pulse latency: sampled at N, pulse after N+2, count after N+3
            ioin[0] = 1'b1;
            step(1);
            step(1);
            ioin[0] = 1'b0;
            check("lat_ep_n1", int'(edge_pulse[0]), 0);
            step(1);
            check("lat_ep_n2", int'(edge_pulse[0]), 1);
            check("lat_c0_n2", int'(count0), 0);
            step(1);
            check("lat_ep_n3", int'(edge_pulse[0]), 0);
            check("lat_c0_n3", int'(count0), 1);
            exp_edges[0]++;
            step(4);
        end
        do_clr();
        check_counts("clr0", 0, 0, 0);

        // Table: clean pulses, glitch, multi-channel events
        for (int v = 0; v < 6; v++) begin
            pulse(tbl[v].mask, tbl[v].shrt ? SHORT : LONG, LONG);
            check_counts($sformatf("vec%0d", v), tbl[v].e0, tbl[v].e1, tbl[v].e2);
            check($sformatf("vec%0d_led", v), int'(led), tbl[v].e0);
        end

        // Wrap through 0xFF on channel 2
        do_clr();
        for (int k = 1; k <= 257; k++) begin
            pulse(3'b100, LONG, LONG);
            if (k == 255) check("wrap_255", int'(count2), 255);
            if (k == 256) check("wrap_256", int'(count2), 0);
        end
        check("wrap_257", int'(count2), 1);

        // clr coincident with edge_pulse[2] drops the event
        begin
            bit seen = 1'b0;
            ioin[2] = 1'b1;
            for (int c = 0; c < 400 && !seen; c++) begin
                step(1);
                if (edge_pulse[2]) seen = 1'b1;
            end
            check("clr_ep2_seen", int'(seen), 1);
            exp_edges[2]++;
            do_clr();
            check("clr_coinc_c2", int'(count2), 0);
            step(1);
            check("clr_after_c2", int'(count2), 0);
            step(LONG);
            ioin[2] = 1'b0;
            step(LONG);
        end

        // Simultaneous edges, then distinct counts for the LED mux
        do_clr();
        for (int k = 0; k < 5; k++) pulse(3'b111, LONG, LONG);
        check_counts("simul", 5, 5, 5);
        pulse(3'b110, LONG, LONG);
        pulse(3'b100, LONG, LONG);
        check_counts("distinct", 5, 6, 7);
        for (int v = 0; v < 4; v++) begin
            sel = ltbl[v].s;
            #1;
            check($sformatf("led_sel%0d", v), int'(led), ltbl[v].e);
        end

        for (int i = 0; i < 3; i++)
            check($sformatf("epc%0d", i), epc[i], exp_edges[i]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
